// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg: FSM encodings, request-type bit positions and the timeout default
// shared by the load/store unit, its lane aligner and the testbench.
package exu_lsu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rdtype is {signed, byte, half, word}; wtype is {sb, sh, sw}
    localparam int RD_SIGNED = 3;
    localparam int RD_BYTE   = 2;
    localparam int RD_HALF   = 1;
    localparam int RD_WORD   = 0;

    localparam int WT_SB = 2;
    localparam int WT_SH = 1;
    localparam int WT_SW = 0;

    localparam int LSU_TIMEOUT_DEFAULT = 256;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  wtype;
        logic [3:0]  rdtype;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering; store strobes/replicated data
// and load lane extraction with sign or zero extension.
module lsu_lane_align
    import exu_lsu_pkg::*;
(
    input  logic [2:0]  wtype,
    input  logic [3:0]  rdtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        if (wtype[WT_SB]) begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
        end else if (wtype[WT_SH]) begin
            wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            wdata = {2{store_data[15:0]}};
        end else if (wtype[WT_SW]) begin
            wstrb = 4'hF;
            wdata = store_data;
        end
    end

    assign load_byte = load_word[{addr_lo, 3'b000} +: 8];
    assign load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_data = 32'h0;
        if (rdtype[RD_BYTE]) begin
            load_data = {{24{rdtype[RD_SIGNED] & load_byte[7]}}, load_byte};
        end else if (rdtype[RD_HALF]) begin
            load_data = {{16{rdtype[RD_SIGNED] & load_half[15]}}, load_half};
        end else if (rdtype[RD_WORD]) begin
            load_data = load_word;
        end
    end

endmodule

// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit issuing one single-beat access per request on a valid/ready bus.
// Define LSU_MISALIGN_EXC_EN to trap misaligned half/word accesses instead of force-aligning them.
module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_wreq,
    input  logic        i_mem_rreq,
    input  logic [2:0]  i_mem_wtype,
    input  logic [3:0]  i_mem_rdtype,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        o_lsu_busy,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic        o_lsu_err,
    output logic        o_bus_req_valid,
    input  logic        i_bus_req_ready,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_wstrb,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_rsp_valid,
    input  logic        i_bus_rsp_err,
    input  logic [31:0] i_bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    lsu_req_t         req;
    logic [CNT_W-1:0] tmo_cnt;
    logic [31:0]      wb_data_q;
    logic             wb_err_q;

    logic             new_req;
    logic             is_half;
    logic             is_word;
    logic             trap;
    logic             tmo_hit;
    logic [31:0]      cap_addr;
    logic [31:0]      load_data;

    assign new_req = i_mem_wreq | i_mem_rreq;
    assign is_half = i_mem_wreq ? i_mem_wtype[WT_SH] : i_mem_rdtype[RD_HALF];
    assign is_word = i_mem_wreq ? i_mem_wtype[WT_SW] : i_mem_rdtype[RD_WORD];

`ifdef LSU_MISALIGN_EXC_EN
    assign trap     = (is_half && i_mem_addr[0]) || (is_word && i_mem_addr[1:0] != 2'b00);
    assign cap_addr = i_mem_addr;
`else
    assign trap     = 1'b0;
    assign cap_addr = {i_mem_addr[31:2],
                       is_word ? 1'b0 : i_mem_addr[1],
                       (is_word || is_half) ? 1'b0 : i_mem_addr[0]};
`endif

    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    lsu_lane_align u_align (
        .wtype      (req.wtype),
        .rdtype     (req.rdtype),
        .addr_lo    (req.addr[1:0]),
        .store_data (req.wdata),
        .load_word  (i_bus_rdata),
        .wstrb      (o_bus_wstrb),
        .wdata      (o_bus_wdata),
        .load_data  (load_data)
    );

    // Handshake and response both beat the timeout when they land on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (new_req) state_nxt = trap ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (i_bus_req_ready)  state_nxt = ST_RSP;
                else if (tmo_hit)     state_nxt = ST_DONE;
            end
            ST_RSP: begin
                if (i_bus_rsp_valid)  state_nxt = ST_DONE;
                else if (tmo_hit)     state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req       <= '0;
            tmo_cnt   <= '0;
            wb_data_q <= 32'h0;
            wb_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (new_req) begin
                        req.addr   <= cap_addr;
                        req.we     <= i_mem_wreq;
                        req.wtype  <= i_mem_wreq ? i_mem_wtype : 3'b000;
                        req.rdtype <= i_mem_wreq ? 4'b0000 : i_mem_rdtype;
                        req.wdata  <= i_mem_wdata;
                        tmo_cnt    <= '0;
                        wb_err_q   <= trap;
                        wb_data_q  <= 32'h0;
                    end
                end
                ST_REQ: begin
                    if (i_bus_req_ready) begin
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        wb_err_q  <= 1'b1;
                        wb_data_q <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RSP: begin
                    if (i_bus_rsp_valid) begin
                        wb_err_q  <= i_bus_rsp_err;
                        wb_data_q <= (i_bus_rsp_err || req.we) ? 32'h0 : load_data;
                    end else if (tmo_hit) begin
                        wb_err_q  <= 1'b1;
                        wb_data_q <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    wb_err_q  <= 1'b0;
                    wb_data_q <= 32'h0;
                end
            endcase
        end
    end

    assign o_lsu_busy      = (state == ST_IDLE && new_req) || state == ST_REQ || state == ST_RSP;
    assign o_wb_valid      = (state == ST_DONE);
    assign o_wb_data       = wb_data_q;
    assign o_lsu_err       = wb_err_q;
    assign o_bus_req_valid = (state == ST_REQ);
    assign o_bus_addr      = {req.addr[31:2], 2'b00};
    assign o_bus_we        = req.we;

    // A simultaneous store and load request is a pipeline bug; the store wins in hardware.
    a_no_dual_req: assert property (@(posedge clk) disable iff (rst)
        !(state == ST_IDLE && i_mem_wreq && i_mem_rreq));

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: directed transactions against exu_lsu with a bus-level reference model
// and a per-cycle compare process; hand-computed literals pin the model.
module tb_exu_lsu;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        i_mem_wreq;
    logic        i_mem_rreq;
    logic [2:0]  i_mem_wtype;
    logic [3:0]  i_mem_rdtype;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic        o_lsu_busy;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic        o_lsu_err;
    logic        o_bus_req_valid;
    logic        i_bus_req_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_we;
    logic [3:0]  o_bus_wstrb;
    logic [31:0] o_bus_wdata;
    logic        i_bus_rsp_valid;
    logic        i_bus_rsp_err;
    logic [31:0] i_bus_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } wb_t;

    wb_t         exp_q[$];
    logic        bus_armed;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          cyc;
    int          n_checks;
    int          n_fail;

    exu_lsu #(.TIMEOUT_CYC(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_mem_wreq      (i_mem_wreq),
        .i_mem_rreq      (i_mem_rreq),
        .i_mem_wtype     (i_mem_wtype),
        .i_mem_rdtype    (i_mem_rdtype),
        .i_mem_addr      (i_mem_addr),
        .i_mem_wdata     (i_mem_wdata),
        .o_lsu_busy      (o_lsu_busy),
        .o_wb_valid      (o_wb_valid),
        .o_wb_data       (o_wb_data),
        .o_lsu_err       (o_lsu_err),
        .o_bus_req_valid (o_bus_req_valid),
        .i_bus_req_ready (i_bus_req_ready),
        .o_bus_addr      (o_bus_addr),
        .o_bus_we        (o_bus_we),
        .o_bus_wstrb     (o_bus_wstrb),
        .o_bus_wdata     (o_bus_wdata),
        .i_bus_rsp_valid (i_bus_rsp_valid),
        .i_bus_rsp_err   (i_bus_rsp_err),
        .i_bus_rdata     (i_bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Access size in bytes from the one-hot type fields.
    function automatic int size_of(input logic st, input logic [2:0] wt, input logic [3:0] rt);
        if (st) return wt[2] ? 1 : (wt[1] ? 2 : 4);
        return rt[2] ? 1 : (rt[1] ? 2 : 4);
    endfunction

    function automatic logic [3:0] model_strb(input int n, input int off);
        logic [7:0] m;
        m = 8'(((1 << n) - 1) << off);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int n);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] rt, input int off, input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int          n;
        n = size_of(1'b0, 3'b000, rt);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * off)) & mask;
        if (rt[3] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Compare process: bus fields while the model expects a request, writebacks against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus_armed) begin
                checkOutput("bus_valid_idle", {31'b0, o_bus_req_valid}, 32'h0);
            end else if (o_bus_req_valid) begin
                checkOutput("bus_addr", o_bus_addr, exp_addr);
                checkOutput("bus_we", {31'b0, o_bus_we}, {31'b0, exp_we});
                if (exp_we) begin
                    checkOutput("bus_wstrb", {28'b0, o_bus_wstrb}, {28'b0, exp_strb});
                    checkOutput("bus_wdata", o_bus_wdata, exp_wdata);
                end
            end
            if (o_wb_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("wb_unexpected", {31'b0, o_wb_valid}, 32'h0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    checkOutput("model_wb_data", o_wb_data, e.data);
                    checkOutput("model_wb_err", {31'b0, o_lsu_err}, {31'b0, e.err});
                    checkOutput("busy_at_wb", {31'b0, o_lsu_busy}, 32'h0);
                end
            end
        end
    end

    // Runs one transaction starting in an IDLE cycle (posedge+1) and returns in the next IDLE cycle.
    task automatic applyStimulus(
        input string       name,
        input logic        st,
        input logic [2:0]  wt,
        input logic [3:0]  rt,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          d,
        input int          r,
        input logic        rerr,
        input logic        no_rsp,
        input logic [31:0] rd,
        input logic [31:0] lit_data,
        input logic        lit_err,
        input int          lit_lat
    );
        int   n, off, cyc0, lat_model;
        logic trap, seen;
        wb_t  e;
        n   = size_of(st, wt, rt);
        off = int'(a[1:0]);
`ifdef LSU_MISALIGN_EXC_EN
        trap = (off % n) != 0;
`else
        trap = 1'b0;
`endif
        off       = (off / n) * n;
        exp_addr  = a & ~32'h3;
        exp_we    = st;
        exp_strb  = model_strb(n, off);
        exp_wdata = model_wdata(wd, n);
        if (trap) begin
            e.data = 32'h0; e.err = 1'b1; lat_model = 1;
        end else if (no_rsp) begin
            e.data = 32'h0; e.err = 1'b1; lat_model = d + 2 + TMO;
        end else if (rerr) begin
            e.data = 32'h0; e.err = 1'b1; lat_model = d + r + 3;
        end else begin
            e.data = st ? 32'h0 : model_load(rt, off, rd); e.err = 1'b0; lat_model = d + r + 3;
        end
        checkOutput({"pin_", name, "_data"}, e.data, lit_data);
        checkOutput({"pin_", name, "_err"}, {31'b0, e.err}, {31'b0, lit_err});
        checkOutput({"pin_", name, "_lat"}, lat_model, lit_lat);
        exp_q.push_back(e);
        bus_armed = !trap;

        i_mem_wreq      = st;
        i_mem_rreq      = !st;
        i_mem_wtype     = wt;
        i_mem_rdtype    = rt;
        i_mem_addr      = a;
        i_mem_wdata     = wd;
        i_bus_rsp_valid = 1'b1;
        i_bus_rsp_err   = 1'b1;
        i_bus_rdata     = 32'h5555_5555;
        cyc0 = cyc;
        @(negedge clk);
        checkOutput({name, "_busy_accept"}, {31'b0, o_lsu_busy}, 32'h1);
        @(posedge clk); #1;
        i_mem_wreq   = 1'b0;
        i_mem_rreq   = 1'b0;
        i_mem_wtype  = 3'b111;
        i_mem_rdtype = 4'b1111;
        i_mem_addr   = 32'hFFFF_FFFF;
        i_mem_wdata  = ~wd;
        if (!trap) begin
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                checkOutput({name, "_valid_stall"}, {31'b0, o_bus_req_valid}, 32'h1);
                checkOutput({name, "_busy_stall"}, {31'b0, o_lsu_busy}, 32'h1);
                @(posedge clk); #1;
            end
            i_bus_req_ready = 1'b1;
            @(posedge clk); #1;
            i_bus_req_ready = 1'b0;
            i_bus_rsp_valid = 1'b0;
            i_bus_rsp_err   = 1'b0;
            if (!no_rsp) begin
                for (int k = 0; k < r; k++) begin
                    @(posedge clk); #1;
                end
                i_bus_rsp_valid = 1'b1;
                i_bus_rsp_err   = rerr;
                i_bus_rdata     = rd;
                @(posedge clk); #1;
                i_bus_rsp_valid = 1'b0;
                i_bus_rsp_err   = 1'b0;
                i_bus_rdata     = 32'h0;
            end
        end else begin
            i_bus_rsp_valid = 1'b0;
            i_bus_rsp_err   = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (o_wb_valid) seen = 1'b1;
        end
        checkOutput({name, "_wb_seen"}, {31'b0, seen}, 32'h1);
        if (seen) begin
            checkOutput({name, "_latency"}, cyc - cyc0, lit_lat);
            checkOutput({name, "_wb_data"}, o_wb_data, lit_data);
            checkOutput({name, "_wb_err"}, {31'b0, o_lsu_err}, {31'b0, lit_err});
        end
        bus_armed = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        cyc             = 0;
        bus_armed       = 1'b0;
        exp_addr        = 32'h0;
        exp_we          = 1'b0;
        exp_strb        = 4'h0;
        exp_wdata       = 32'h0;
        rst             = 1'b1;
        i_mem_wreq      = 1'b0;
        i_mem_rreq      = 1'b0;
        i_mem_wtype     = 3'b000;
        i_mem_rdtype    = 4'b0000;
        i_mem_addr      = 32'h0;
        i_mem_wdata     = 32'h0;
        i_bus_req_ready = 1'b0;
        i_bus_rsp_valid = 1'b0;
        i_bus_rsp_err   = 1'b0;
        i_bus_rdata     = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'b0, o_lsu_busy}, 32'h0);
        checkOutput("rst_wb_valid", {31'b0, o_wb_valid}, 32'h0);
        checkOutput("rst_wb_data", o_wb_data, 32'h0);
        checkOutput("rst_err", {31'b0, o_lsu_err}, 32'h0);
        checkOutput("rst_req_valid", {31'b0, o_bus_req_valid}, 32'h0);
        checkOutput("rst_bus_addr", o_bus_addr, 32'h0);
        checkOutput("rst_bus_we", {31'b0, o_bus_we}, 32'h0);
        checkOutput("rst_bus_wstrb", {28'b0, o_bus_wstrb}, 32'h0);
        checkOutput("rst_bus_wdata", o_bus_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        checkOutput("pin_sh_strb", {28'b0, model_strb(2, 2)}, 32'hC);
        checkOutput("pin_sh_wdata", model_wdata(32'h0000ABCD, 2), 32'hABCDABCD);
        checkOutput("pin_sb_wdata", model_wdata(32'h12345678, 1), 32'h78787878);

        //            name    st    wt      rt       addr          wdata          d  r  rerr  norsp rdata          lit_data       err  lat
        applyStimulus("sw",   1'b1, 3'b001, 4'b0000, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 3);
        applyStimulus("lb",   1'b0, 3'b000, 4'b1100, 32'h0000_0103, 32'h0,        0, 0, 1'b0, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 3);
        applyStimulus("lbu",  1'b0, 3'b000, 4'b0100, 32'h0000_0103, 32'h0,        0, 1, 1'b0, 1'b0, 32'h80FF_1234, 32'h0000_0080, 1'b0, 4);
        applyStimulus("lh",   1'b0, 3'b000, 4'b1010, 32'h0000_0102, 32'h0,        0, 0, 1'b0, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 3);
        applyStimulus("lhu",  1'b0, 3'b000, 4'b0010, 32'h0000_0102, 32'h0,        0, 0, 1'b0, 1'b0, 32'h8001_7FFF, 32'h0000_8001, 1'b0, 3);
        applyStimulus("lh0",  1'b0, 3'b000, 4'b1010, 32'h0000_0100, 32'h0,        1, 0, 1'b0, 1'b0, 32'h8001_7FFF, 32'h0000_7FFF, 1'b0, 4);
        applyStimulus("sh",   1'b1, 3'b010, 4'b0000, 32'h0000_0102, 32'h0000ABCD, 0, 0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 3);
        applyStimulus("sb",   1'b1, 3'b100, 4'b0000, 32'h0000_0101, 32'h12345678, 0, 2, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 5);
        applyStimulus("stall",1'b0, 3'b000, 4'b0001, 32'h0000_0200, 32'h0,        5, 0, 1'b1, 1'b0, 32'h1234_5678, 32'h0,         1'b1, 8);
        applyStimulus("tmo",  1'b0, 3'b000, 4'b0001, 32'h0000_0300, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 18);
        applyStimulus("b2b",  1'b0, 3'b000, 4'b0001, 32'h0000_0104, 32'h0,        0, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3);
`ifdef LSU_MISALIGN_EXC_EN
        applyStimulus("lwmis",1'b0, 3'b000, 4'b0001, 32'h0000_0102, 32'h0,        0, 0, 1'b0, 1'b0, 32'h1122_3344, 32'h0,         1'b1, 1);
`else
        applyStimulus("lwmis",1'b0, 3'b000, 4'b0001, 32'h0000_0102, 32'h0,        0, 0, 1'b0, 1'b0, 32'h1122_3344, 32'h1122_3344, 1'b0, 3);
`endif

        // Reset while waiting for a response; the late response must not complete anything.
        exp_addr  = 32'h0000_0400;
        exp_we    = 1'b0;
        bus_armed = 1'b1;
        i_mem_rreq   = 1'b1;
        i_mem_rdtype = 4'b0001;
        i_mem_addr   = 32'h0000_0400;
        @(posedge clk); #1;
        i_mem_rreq      = 1'b0;
        i_bus_req_ready = 1'b1;
        @(posedge clk); #1;
        i_bus_req_ready = 1'b0;
        bus_armed       = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'b0, o_lsu_busy}, 32'h0);
        checkOutput("midrst_req_valid", {31'b0, o_bus_req_valid}, 32'h0);
        @(posedge clk); #1;
        rst             = 1'b0;
        i_bus_rsp_valid = 1'b1;
        i_bus_rdata     = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        i_bus_rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_wb", {31'b0, o_wb_valid}, 32'h0);
        end
        @(posedge clk); #1;
        applyStimulus("post", 1'b0, 3'b000, 4'b0001, 32'h0000_0500, 32'h0,       0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3);

        checkOutput("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
